key_dispatcher: RTL and testbench
=================================

// Module: key_dispatcher
// PURPOSE
//  Dynamic work distributor for the parallel RC4 key-search array: splits [0, KEY_MAX] into
//  2^CHUNK_LOG-key chunks and hands them round-robin to whichever arcfour cores are free.
//  Detects the first successful core, latches its key, kills the array and reports progress.
//  Sits between the top-level UI/state logic and the generated core bank.
// PARAMETERS
//  NUM_CORES      8          number of search cores served
//  LOG_NUM_CORES  3          index width, >= clog2(NUM_CORES)
//  KEY_WIDTH      24         key bits (KEY_LENGTH*RAM_WIDTH)
//  KEY_MAX        24'hffffff last key searched, inclusive
//  CHUNK_LOG      16         log2 of keys per chunk
// PORTS
//  clk          in   1                    system clock
//  reset_n      in   1                    asynchronous active-low reset
//  start        in   1                    1-cycle pulse: begin new search from key 0
//  abort        in   1                    1-cycle pulse: stop search, return to IDLE
//  core_done    in   NUM_CORES            per-core 1-cycle pulse: assigned chunk finished
//  core_hit     in   NUM_CORES            qualified by core_done: chunk contained valid key
//  core_key     in   NUM_CORES*KEY_WIDTH  per-core found key, valid with done&hit
//  core_go      out  NUM_CORES            one-hot 1-cycle pulse: core latches dispatch_lo/hi
//  dispatch_lo  out  KEY_WIDTH            first key of issued chunk
//  dispatch_hi  out  KEY_WIDTH            last key of issued chunk, inclusive
//  kill         out  1                    1-cycle pulse: all cores abandon work
//  busy         out  1                    high in RUN or DRAIN
//  found        out  1                    high in FOUND
//  exhausted    out  1                    high in EXHAUSTED
//  found_key    out  KEY_WIDTH            winning key, held until next start
//  found_core   out  LOG_NUM_CORES        index of winning core
//  chunks_done  out  KEY_WIDTH+1          count of chunks completed without hit
// BEHAVIOUR
//  - Reset: every output 0, state IDLE, busy_mask 0, rr pointer 0, next_lo 0.
//  - All outputs registered. States: IDLE, RUN, DRAIN, FOUND, EXHAUSTED.
//  - IDLE/FOUND/EXHAUSTED + start -> RUN; clears found_key, found_core, chunks_done,
//    busy_mask, next_lo, rr pointer. start ignored in RUN/DRAIN.
//  - RUN: each cycle, if any core free (busy_mask[i]=0), issue to first free core at or
//    after rr pointer (wrapping): core_go[i]=1 next edge with dispatch_lo=next_lo,
//    dispatch_hi=min(next_lo+2^CHUNK_LOG-1, KEY_MAX); set busy_mask[i]; rr=i+1 mod NUM_CORES;
//    next_lo += 2^CHUNK_LOG. Max one go per cycle. First go one cycle after entering RUN.
//  - next_lo held in KEY_WIDTH+1 bits; no wrap at 2^KEY_WIDTH. When next_lo > KEY_MAX
//    after an issue -> DRAIN. Final chunk truncated at KEY_MAX if range not chunk-aligned.
//  - core_done[i]: clear busy_mask[i]; if !core_hit[i], chunks_done++. A core freed this
//    cycle may be issued no earlier than the next cycle.
//  - Any done&hit in RUN/DRAIN -> FOUND: latch lowest-index hitting core's key/index
//    (simultaneous hits: lowest index wins); kill pulses 1 cycle; busy_mask cleared;
//    later dones/hits ignored. Hit beats abort and beats last-chunk exhaustion same cycle.
//  - DRAIN: busy_mask==0 (after same-cycle dones applied) with no hit -> EXHAUSTED.
//  - abort in RUN/DRAIN -> IDLE, kill pulses 1 cycle, no go that cycle; no effect elsewhere.
//  - core_done for a core with busy_mask=0 ignored (not counted).
//  - reset_n low mid-operation: immediate return to reset values; core_go/kill drop async.
// TESTING
//  (bench: NUM_CORES=4, KEY_WIDTH=8, KEY_MAX=8'hff, CHUNK_LOG=5 -> 8 chunks)
//  1. start, cores finish no hit -> gos to cores 0,1,2,3 ranges 00-1f..60-7f, then 80-ff
//     issued as freed; EXHAUSTED, chunks_done=8, kill never pulses.
//  2. core2 done&hit key=8'h5a on chunk 40-5f -> FOUND, found_key=5a, found_core=2, 1 kill.
//  3. core1 and core3 hit same cycle (keys 2b, 77) -> found_core=1, found_key=2b.
//  4. KEY_MAX=8'hf0 -> last chunk dispatch_lo=e0, dispatch_hi=f0; no further go; EXHAUSTED.
//  5. abort in RUN after 3 gos -> IDLE next cycle, kill 1 cycle, no go; restart issues 00-1f.
//  6. reset_n low while core_go high -> all outputs 0 at once; start afterwards runs as 1.

Source files
------------

// File: rtl/key_dispatcher_if.sv
// Handshake bundle between the key dispatcher, the UI/state logic and the arcfour core bank.
// master drives control pulses and core results; slave is the dispatcher itself.
interface key_dispatcher_if #(
  parameter int NUM_CORES     = 8,
  parameter int LOG_NUM_CORES = 3,
  parameter int KEY_WIDTH     = 24
);
  logic                           start;
  logic                           abort;
  logic [NUM_CORES-1:0]           core_done;
  logic [NUM_CORES-1:0]           core_hit;
  logic [NUM_CORES*KEY_WIDTH-1:0] core_key;
  logic [NUM_CORES-1:0]           core_go;
  logic [KEY_WIDTH-1:0]           dispatch_lo;
  logic [KEY_WIDTH-1:0]           dispatch_hi;
  logic                           kill;
  logic                           busy;
  logic                           found;
  logic                           exhausted;
  logic [KEY_WIDTH-1:0]           found_key;
  logic [LOG_NUM_CORES-1:0]       found_core;
  logic [KEY_WIDTH:0]             chunks_done;

  modport master (
    output start, abort, core_done, core_hit, core_key,
    input  core_go, dispatch_lo, dispatch_hi, kill, busy, found, exhausted,
           found_key, found_core, chunks_done
  );

  modport slave (
    input  start, abort, core_done, core_hit, core_key,
    output core_go, dispatch_lo, dispatch_hi, kill, busy, found, exhausted,
           found_key, found_core, chunks_done
  );
endinterface

// File: rtl/key_dispatcher.sv
// Round-robin chunk dispatcher for the parallel RC4 key-search core bank; stops the
// array on the first hit and reports the winning key, core and completed chunk count.
module key_dispatcher #(
  parameter int                   NUM_CORES     = 8,
  parameter int                   LOG_NUM_CORES = 3,
  parameter int                   KEY_WIDTH     = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX       = {KEY_WIDTH{1'b1}},
  parameter int                   CHUNK_LOG     = 16
)(
  input logic             clk,
  input logic             reset_n,
  key_dispatcher_if.slave kd
);

  localparam logic [KEY_WIDTH:0] LP_ONE     = {{KEY_WIDTH{1'b0}}, 1'b1};
  localparam logic [KEY_WIDTH:0] LP_CHUNK   = LP_ONE << CHUNK_LOG;
  localparam logic [KEY_WIDTH:0] LP_KEY_MAX = {1'b0, KEY_MAX};

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_DRAIN, S_FOUND, S_EXHAUSTED
  } state_t;

  state_t                   r_state;
  logic [NUM_CORES-1:0]     r_busy_mask;
  logic [LOG_NUM_CORES-1:0] r_rr;
  logic [KEY_WIDTH:0]       r_next_lo;
  logic [NUM_CORES-1:0]     r_core_go;
  logic [KEY_WIDTH-1:0]     r_dispatch_lo;
  logic [KEY_WIDTH-1:0]     r_dispatch_hi;
  logic                     r_kill;
  logic                     r_busy;
  logic                     r_found;
  logic                     r_exhausted;
  logic [KEY_WIDTH-1:0]     r_found_key;
  logic [LOG_NUM_CORES-1:0] r_found_core;
  logic [KEY_WIDTH:0]       r_chunks_done;

  logic [NUM_CORES-1:0]     w_done_vld;
  logic [NUM_CORES-1:0]     w_hit_vld;
  logic [NUM_CORES-1:0]     w_busy_after_done;
  logic                     w_any_hit;
  logic [LOG_NUM_CORES-1:0] w_hit_idx;
  logic [KEY_WIDTH-1:0]     w_hit_key;
  logic [KEY_WIDTH:0]       w_nohit_cnt;
  logic                     w_pick_vld;
  logic [LOG_NUM_CORES-1:0] w_pick_idx;
  logic [NUM_CORES-1:0]     w_pick_oh;
  logic [LOG_NUM_CORES-1:0] w_rr_next;
  logic [KEY_WIDTH:0]       w_chunk_end;
  logic [KEY_WIDTH-1:0]     w_hi;
  logic [KEY_WIDTH:0]       w_next_lo_inc;

  // Dones from idle cores are spurious and never count or hit.
  assign w_done_vld        = kd.core_done & r_busy_mask;
  assign w_hit_vld         = w_done_vld & kd.core_hit;
  assign w_any_hit         = |w_hit_vld;
  assign w_busy_after_done = r_busy_mask & ~w_done_vld;

  always_comb begin
    w_hit_idx   = '0;
    w_hit_key   = '0;
    w_nohit_cnt = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (w_hit_vld[i]) begin
        w_hit_idx = LOG_NUM_CORES'(i);
        w_hit_key = kd.core_key[i*KEY_WIDTH +: KEY_WIDTH];
      end
      if (w_done_vld[i] && !kd.core_hit[i]) begin
        w_nohit_cnt = w_nohit_cnt + LP_ONE;
      end
    end
  end

  // Selection looks at the pre-done mask, so a core freed this cycle waits one cycle.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    w_pick_oh  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!w_pick_vld && !r_busy_mask[i] && (i >= int'(r_rr))) begin
        w_pick_vld   = 1'b1;
        w_pick_idx   = LOG_NUM_CORES'(i);
        w_pick_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!w_pick_vld && !r_busy_mask[i]) begin
        w_pick_vld   = 1'b1;
        w_pick_idx   = LOG_NUM_CORES'(i);
        w_pick_oh[i] = 1'b1;
      end
    end
  end

  assign w_rr_next     = (w_pick_idx == LOG_NUM_CORES'(NUM_CORES - 1)) ? '0
                                                                       : w_pick_idx + LOG_NUM_CORES'(1);
  assign w_chunk_end   = r_next_lo + LP_CHUNK - LP_ONE;
  assign w_hi          = (w_chunk_end > LP_KEY_MAX) ? KEY_MAX : w_chunk_end[KEY_WIDTH-1:0];
  assign w_next_lo_inc = r_next_lo + LP_CHUNK;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_busy_mask   <= '0;
      r_rr          <= '0;
      r_next_lo     <= '0;
      r_core_go     <= '0;
      r_dispatch_lo <= '0;
      r_dispatch_hi <= '0;
      r_kill        <= 1'b0;
      r_busy        <= 1'b0;
      r_found       <= 1'b0;
      r_exhausted   <= 1'b0;
      r_found_key   <= '0;
      r_found_core  <= '0;
      r_chunks_done <= '0;
    end else begin
      r_core_go <= '0;
      r_kill    <= 1'b0;
      case (r_state)
        S_IDLE, S_FOUND, S_EXHAUSTED: begin
          if (kd.start) begin
            r_state       <= S_RUN;
            r_busy        <= 1'b1;
            r_found       <= 1'b0;
            r_exhausted   <= 1'b0;
            r_found_key   <= '0;
            r_found_core  <= '0;
            r_chunks_done <= '0;
            r_busy_mask   <= '0;
            r_next_lo     <= '0;
            r_rr          <= '0;
          end
        end
        S_RUN, S_DRAIN: begin
          r_chunks_done <= r_chunks_done + w_nohit_cnt;
          // Priority: hit, then abort, then normal issue / drain progress.
          if (w_any_hit) begin
            r_state      <= S_FOUND;
            r_busy       <= 1'b0;
            r_found      <= 1'b1;
            r_kill       <= 1'b1;
            r_busy_mask  <= '0;
            r_found_key  <= w_hit_key;
            r_found_core <= w_hit_idx;
          end else if (kd.abort) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_kill      <= 1'b1;
            r_busy_mask <= '0;
          end else if (r_state == S_RUN && w_pick_vld) begin
            r_core_go     <= w_pick_oh;
            r_dispatch_lo <= r_next_lo[KEY_WIDTH-1:0];
            r_dispatch_hi <= w_hi;
            r_busy_mask   <= w_busy_after_done | w_pick_oh;
            r_rr          <= w_rr_next;
            r_next_lo     <= w_next_lo_inc;
            if (w_next_lo_inc > LP_KEY_MAX) begin
              r_state <= S_DRAIN;
            end
          end else begin
            r_busy_mask <= w_busy_after_done;
            if (r_state == S_DRAIN && w_busy_after_done == '0) begin
              r_state     <= S_EXHAUSTED;
              r_busy      <= 1'b0;
              r_exhausted <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign kd.core_go     = r_core_go;
  assign kd.dispatch_lo = r_dispatch_lo;
  assign kd.dispatch_hi = r_dispatch_hi;
  assign kd.kill        = r_kill;
  assign kd.busy        = r_busy;
  assign kd.found       = r_found;
  assign kd.exhausted   = r_exhausted;
  assign kd.found_key   = r_found_key;
  assign kd.found_core  = r_found_core;
  assign kd.chunks_done = r_chunks_done;

endmodule

// File: tb/tb_key_dispatcher.sv
// Scoreboard bench for key_dispatcher: two instances (KEY_MAX ff and f0) share stimulus;
// a negedge monitor pops expected go/kill/found/exhausted events from queues.
module tb_key_dispatcher;
  localparam int NC  = 4;
  localparam int LNC = 2;
  localparam int KW  = 8;
  localparam int CL  = 5;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic             t_start, t_abort, sel_b;
  logic [NC-1:0]    t_done, t_hit;
  logic [NC*KW-1:0] t_key;

  key_dispatcher_if #(.NUM_CORES(NC), .LOG_NUM_CORES(LNC), .KEY_WIDTH(KW)) if_a ();
  key_dispatcher_if #(.NUM_CORES(NC), .LOG_NUM_CORES(LNC), .KEY_WIDTH(KW)) if_b ();

  assign if_a.start = t_start;  assign if_b.start = t_start;
  assign if_a.abort = t_abort;  assign if_b.abort = t_abort;
  assign if_a.core_done = t_done; assign if_b.core_done = t_done;
  assign if_a.core_hit  = t_hit;  assign if_b.core_hit  = t_hit;
  assign if_a.core_key  = t_key;  assign if_b.core_key  = t_key;

  key_dispatcher #(.NUM_CORES(NC), .LOG_NUM_CORES(LNC), .KEY_WIDTH(KW),
                   .KEY_MAX(8'hff), .CHUNK_LOG(CL))
    u_dut_a (.clk(clk), .reset_n(reset_n), .kd(if_a.slave));
  key_dispatcher #(.NUM_CORES(NC), .LOG_NUM_CORES(LNC), .KEY_WIDTH(KW),
                   .KEY_MAX(8'hf0), .CHUNK_LOG(CL))
    u_dut_b (.clk(clk), .reset_n(reset_n), .kd(if_b.slave));

  logic [NC-1:0]  m_go;
  logic [KW-1:0]  m_lo, m_hi, m_fkey;
  logic           m_kill, m_busy, m_found, m_exh;
  logic [LNC-1:0] m_fcore;
  logic [KW:0]    m_chunks;

  always_comb begin
    if (sel_b) begin
      m_go = if_b.core_go; m_lo = if_b.dispatch_lo; m_hi = if_b.dispatch_hi;
      m_kill = if_b.kill; m_busy = if_b.busy; m_found = if_b.found; m_exh = if_b.exhausted;
      m_fkey = if_b.found_key; m_fcore = if_b.found_core; m_chunks = if_b.chunks_done;
    end else begin
      m_go = if_a.core_go; m_lo = if_a.dispatch_lo; m_hi = if_a.dispatch_hi;
      m_kill = if_a.kill; m_busy = if_a.busy; m_found = if_a.found; m_exh = if_a.exhausted;
      m_fkey = if_a.found_key; m_fcore = if_a.found_core; m_chunks = if_a.chunks_done;
    end
  end

  typedef struct packed { logic [LNC-1:0] idx; logic [KW-1:0] lo; logic [KW-1:0] hi; } go_t;
  typedef struct packed { logic [KW-1:0] key; logic [LNC-1:0] core; } found_t;

  go_t         q_go[$];
  int          q_kill[$];
  found_t      q_found[$];
  logic [KW:0] q_exh[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  logic prev_found = 1'b0;
  logic prev_exh   = 1'b0;

  always @(negedge clk) begin
    go_t    e;
    found_t f;
    if (m_go != '0) begin
      if (q_go.size() == 0) check("unexpected_go", 32'(m_go), 32'h0);
      else begin
        e = q_go.pop_front();
        check("go_onehot", 32'(m_go), 32'(NC'(1) << e.idx));
        check("go_lo", 32'(m_lo), 32'(e.lo));
        check("go_hi", 32'(m_hi), 32'(e.hi));
      end
    end
    if (m_kill) begin
      if (q_kill.size() == 0) check("unexpected_kill", 32'(m_kill), 32'h0);
      else begin
        void'(q_kill.pop_front());
        check("kill_busy", 32'(m_busy), 32'h0);
      end
    end
    if (m_found && !prev_found) begin
      if (q_found.size() == 0) check("unexpected_found", 32'(m_found), 32'h0);
      else begin
        f = q_found.pop_front();
        check("found_key", 32'(m_fkey), 32'(f.key));
        check("found_core", 32'(m_fcore), 32'(f.core));
        check("found_chunks", 32'(m_chunks), 32'h0);
      end
    end
    if (m_exh && !prev_exh) begin
      if (q_exh.size() == 0) check("unexpected_exhausted", 32'(m_exh), 32'h0);
      else begin
        check("exh_chunks", 32'(m_chunks), 32'(q_exh.pop_front()));
        check("exh_busy", 32'(m_busy), 32'h0);
        check("exh_kill", 32'(m_kill), 32'h0);
      end
    end
    prev_found <= m_found;
    prev_exh   <= m_exh;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_go(input int idx, input int lo, input int hi);
    go_t g;
    g.idx = LNC'(idx);
    g.lo  = KW'(lo);
    g.hi  = KW'(hi);
    q_go.push_back(g);
  endtask

  task automatic pulse_start();
    t_start = 1'b1;
    step();
    t_start = 1'b0;
  endtask

  task automatic do_done(input logic [NC-1:0] d, input logic [NC-1:0] h,
                         input logic [NC*KW-1:0] k);
    t_done = d; t_hit = h; t_key = k;
    step();
    t_done = '0; t_hit = '0; t_key = '0;
    step();
  endtask

  task automatic issue_first4();
    push_go(0, 8'h00, 8'h1f); push_go(1, 8'h20, 8'h3f);
    push_go(2, 8'h40, 8'h5f); push_go(3, 8'h60, 8'h7f);
    pulse_start();
    repeat (4) step();
  endtask

  task automatic end_check(input string tag);
    step();
    check({tag, "_go_q"},    32'(q_go.size()), 32'h0);
    check({tag, "_kill_q"},  32'(q_kill.size()), 32'h0);
    check({tag, "_found_q"}, 32'(q_found.size()), 32'h0);
    check({tag, "_exh_q"},   32'(q_exh.size()), 32'h0);
  endtask

  task automatic run_full(input int last_hi);
    issue_first4();
    push_go(0, 8'h80, 8'h9f); do_done(4'b0001, '0, '0);
    push_go(1, 8'ha0, 8'hbf); do_done(4'b0010, '0, '0);
    push_go(2, 8'hc0, 8'hdf); do_done(4'b0100, '0, '0);
    push_go(3, 8'he0, last_hi); do_done(4'b1000, '0, '0);
    do_done(4'b0001, '0, '0);
    do_done(4'b0010, '0, '0);
    do_done(4'b0100, '0, '0);
    q_exh.push_back(9'd8);
    do_done(4'b1000, '0, '0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_go"},     32'(m_go), 32'h0);
    check({tag, "_kill"},   32'(m_kill), 32'h0);
    check({tag, "_flags"},  32'({m_busy, m_found, m_exh}), 32'h0);
    check({tag, "_fkey"},   32'(m_fkey), 32'h0);
    check({tag, "_fcore"},  32'(m_fcore), 32'h0);
    check({tag, "_chunks"}, 32'(m_chunks), 32'h0);
    check({tag, "_range"},  32'({m_lo, m_hi}), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    found_t fe;
    reset_n = 1'b1; sel_b = 1'b0;
    t_start = 1'b0; t_abort = 1'b0; t_done = '0; t_hit = '0; t_key = '0;
    #2 reset_n = 1'b0;
    #2 check_zero("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    step();

    // Full search with no hit.
    run_full(8'hff);
    end_check("t1");

    // Single hit on core 2.
    issue_first4();
    fe.key = 8'h5a; fe.core = 2'd2; q_found.push_back(fe); q_kill.push_back(1);
    do_done(4'b0100, 4'b0100, {8'h00, 8'h5a, 8'h00, 8'h00});
    do_done(4'b0001, 4'b0000, '0);
    check("t2_late_done_chunks", 32'(m_chunks), 32'h0);
    check("t2_found_held", 32'(m_found), 32'h1);
    end_check("t2");

    // Simultaneous hits on cores 1 and 3.
    issue_first4();
    fe.key = 8'h2b; fe.core = 2'd1; q_found.push_back(fe); q_kill.push_back(1);
    do_done(4'b1010, 4'b1010, {8'h77, 8'h00, 8'h2b, 8'h00});
    end_check("t3");

    // Abort after three issues, then restart.
    push_go(0, 8'h00, 8'h1f); push_go(1, 8'h20, 8'h3f); push_go(2, 8'h40, 8'h5f);
    pulse_start();
    repeat (3) step();
    q_kill.push_back(1);
    t_abort = 1'b1;
    step();
    t_abort = 1'b0;
    check("t5_abort_go", 32'(m_go), 32'h0);
    check("t5_abort_busy", 32'(m_busy), 32'h0);
    check("t5_abort_kill", 32'(m_kill), 32'h1);
    step();
    check("t5_kill_pulse", 32'(m_kill), 32'h0);
    issue_first4();
    q_kill.push_back(1);
    t_abort = 1'b1;
    step();
    t_abort = 1'b0;
    end_check("t5");

    // Asynchronous reset while a go is on the bus.
    pulse_start();
    step();
    check("t6_go_before_reset", 32'(m_go), 32'h1);
    #1 reset_n = 1'b0;
    #1 check_zero("t6_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    step();
    run_full(8'hff);
    end_check("t6");

    // Non-aligned KEY_MAX truncates the final chunk.
    sel_b = 1'b1;
    run_full(8'hf0);
    end_check("t4");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
